// File: rtl/jtsdram_test_seq.sv
// Pass sequencer for the per-bank SDRAM testers: starts the enabled testers, waits for them, and accumulates errors.
// Optional per-pass watchdog enabled by defining JTSDRAM_TIMEOUT_EN.
module jtsdram_test_seq #(
  parameter int BANKS = 4,
  parameter int PASSW = 8,
  parameter int TOW   = 24
) (
  input  logic             rst,
  input  logic             clk,
  input  logic             run,
  input  logic             clr,
  input  logic             stop_on_err,
  input  logic [BANKS-1:0] bank_en,
  input  logic [BANKS-1:0] bank_done,
  input  logic [BANKS-1:0] bank_bad,
  output logic [BANKS-1:0] bank_start,
  output logic [BANKS-1:0] bank_we,
  output logic [BANKS-1:0] bank_slow,
  output logic [PASSW-1:0] pass_cnt,
  output logic [BANKS-1:0] bad_mask,
  output logic             fail,
  output logic             busy,
  output logic             timeout,
  output logic [2:0]       state_dbg
);

  // Tester handshake: bank_start is a one-cycle request per enabled bank; a tester
  // drops done the cycle after start and raises it (level) when its pass ends.
  // Stale done is therefore only trusted from the WAIT state onwards.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_ARM   = 3'd2,
    S_WAIT  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [BANKS-1:0] en_l;
  logic [BANKS-1:0] fail_bits;
  logic [BANKS-1:0] bad_mask_d;
  logic             all_done;
  logic             pass_end;
  logic             new_bad;
  logic             do_clr;
  logic             to_hit;

  assign state_dbg = state_q;
  assign all_done  = ((bank_done & en_l) == en_l);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    bank_start = '0;
    busy       = 1'b0;
    do_clr     = 1'b0;
    pass_end   = 1'b0;
    fail_bits  = bank_bad & en_l;
    if (to_hit) fail_bits = fail_bits | (en_l & ~bank_done);
    new_bad    = |(fail_bits & ~bad_mask);
    case (state_q)
      S_IDLE: begin
        do_clr = clr;
        if (run && |bank_en) state_d = S_START;
      end
      S_START: begin
        busy       = 1'b1;
        bank_start = bank_en;
        state_d    = S_ARM;
      end
      S_ARM: begin
        busy    = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        busy     = 1'b1;
        pass_end = all_done || to_hit;
        if (pass_end) begin
          if (new_bad && stop_on_err) state_d = S_HALT;
          else if (run)               state_d = S_START;
          else                        state_d = S_IDLE;
        end
      end
      S_HALT: begin
        do_clr = clr;
        if (!run) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (do_clr)        bad_mask_d = '0;
    else if (pass_end) bad_mask_d = bad_mask | fail_bits;
    else               bad_mask_d = bad_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_l      <= '0;
      bank_we   <= '0;
      bank_slow <= '0;
      pass_cnt  <= '0;
      bad_mask  <= '0;
      fail      <= 1'b0;
    end else begin
      bad_mask <= bad_mask_d;
      fail     <= |bad_mask_d;
      if (do_clr)        pass_cnt <= '0;
      else if (pass_end) pass_cnt <= pass_cnt + 1'b1;
      // Mode follows the pass count: read fast, read slow, r/w fast, r/w slow.
      if (state_q == S_START) begin
        en_l      <= bank_en;
        bank_we   <= {BANKS{pass_cnt[1]}};
        bank_slow <= {BANKS{pass_cnt[0]}};
      end
    end
  end

`ifdef JTSDRAM_TIMEOUT_EN
  logic [TOW-1:0] to_cnt;

  assign to_hit = (state_q == S_WAIT) && !all_done && (to_cnt == '1);

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      if (state_q == S_START)     to_cnt <= '0;
      else if (state_q == S_WAIT) to_cnt <= to_cnt + 1'b1;
      if (do_clr)      timeout <= 1'b0;
      else if (to_hit) timeout <= 1'b1;
    end
  end
`else
  // Without the watchdog WAIT blocks until every enabled tester is done.
  assign to_hit  = 1'b0;
  assign timeout = 1'b0 && (TOW > 0);
`endif

endmodule

// File: tb/tb_jtsdram_test_seq.sv
// Directed bench for jtsdram_test_seq: pass-level vector table plus hand sequences for HALT, mid-pass changes, stale done and reset.
module tb_jtsdram_test_seq;

  localparam int BANKS = 4;
  localparam int PASSW = 8;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_START = 3'd1, ST_ARM = 3'd2,
                         ST_WAIT = 3'd3, ST_HALT = 3'd4;

  logic             clk = 1'b0;
  logic             rst, run, clr, stop_on_err;
  logic [BANKS-1:0] bank_en, bank_done, bank_bad;
  logic [BANKS-1:0] bank_start, bank_we, bank_slow, bad_mask;
  logic [PASSW-1:0] pass_cnt;
  logic             fail, busy, timeout;
  logic [2:0]       state_dbg;

  int n_vec = 0;
  int n_err = 0;

  // Clock / reset
  always #5 clk = ~clk;

  jtsdram_test_seq #(.BANKS(BANKS), .PASSW(PASSW), .TOW(24)) dut (
    .rst(rst), .clk(clk), .run(run), .clr(clr), .stop_on_err(stop_on_err),
    .bank_en(bank_en), .bank_done(bank_done), .bank_bad(bank_bad),
    .bank_start(bank_start), .bank_we(bank_we), .bank_slow(bank_slow),
    .pass_cnt(pass_cnt), .bad_mask(bad_mask), .fail(fail), .busy(busy),
    .timeout(timeout), .state_dbg(state_dbg)
  );

  // Tester model: done drops on the start edge and rises dly edges later.
  logic [BANKS-1:0] mdl_done = '0;
  logic [BANKS-1:0] man_done = '0;
  logic             man_mode = 1'b0;
  logic [BANKS-1:0] bad_cfg  = '0;
  int               cnt[BANKS];
  int               dly[BANKS];

  assign bank_done = man_mode ? man_done : mdl_done;
  assign bank_bad  = bad_cfg;

  always @(posedge clk) begin
    for (int i = 0; i < BANKS; i++) begin
      if (rst) begin
        cnt[i]      <= 0;
        mdl_done[i] <= 1'b0;
      end else if (bank_start[i]) begin
        cnt[i]      <= dly[i];
        mdl_done[i] <= 1'b0;
      end else if (cnt[i] != 0) begin
        cnt[i] <= cnt[i] - 1;
        if (cnt[i] == 1) mdl_done[i] <= 1'b1;
      end
    end
  end

  typedef struct {
    logic [3:0] en;
    logic [3:0] bad;
    logic       stop;
    logic       keep_run;
    logic [3:0] exp_start;
    logic       exp_we;
    logic       exp_slow;
    logic [7:0] exp_cnt;
    logic [3:0] exp_mask;
    logic       exp_fail;
    logic [2:0] exp_state;
    logic       exp_busy;
  } vec_t;

  vec_t tbl[7];

  // Scoreboard
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_start(input string tag, input logic [3:0] exp);
    int t = 0;
    while (bank_start == '0 && t < 20) begin
      tick();
      t++;
    end
    chk({tag, "_start"}, 32'(bank_start), 32'(exp));
  endtask

  // Driver: one full pass described by a table record.
  task automatic apply_vec(input vec_t v, input string tag);
    logic [PASSW-1:0] prev;
    int t;
    bank_en     = v.en;
    bad_cfg     = v.bad;
    stop_on_err = v.stop;
    run         = 1'b1;
    #1;
    wait_start(tag, v.exp_start);
    prev = pass_cnt;
    tick();
    chk({tag, "_pulse"}, 32'(bank_start), 32'h0);
    chk({tag, "_mode"}, 32'({bank_we, bank_slow}), 32'({{BANKS{v.exp_we}}, {BANKS{v.exp_slow}}}));
    if (!v.keep_run) run = 1'b0;
    t = 0;
    while (pass_cnt == prev && t < 200) begin
      tick();
      t++;
    end
    chk({tag, "_cnt"}, 32'(pass_cnt), 32'(v.exp_cnt));
    chk({tag, "_mask"}, 32'(bad_mask), 32'(v.exp_mask));
    chk({tag, "_fail"}, 32'(fail), 32'(v.exp_fail));
    chk({tag, "_state"}, 32'(state_dbg), 32'(v.exp_state));
    chk({tag, "_busy"}, 32'(busy), 32'(v.exp_busy));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int el;
    logic ok;
    logic [PASSW-1:0] prev;

    //         en     bad    stp   run   start  we    slow  cnt    mask   fail  state     busy
    tbl[0] = '{4'hF, 4'h0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 8'd1, 4'h0, 1'b0, ST_START, 1'b1};
    tbl[1] = '{4'hF, 4'h0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b1, 8'd2, 4'h0, 1'b0, ST_START, 1'b1};
    tbl[2] = '{4'hF, 4'h0, 1'b0, 1'b1, 4'hF, 1'b1, 1'b0, 8'd3, 4'h0, 1'b0, ST_START, 1'b1};
    tbl[3] = '{4'hF, 4'h0, 1'b0, 1'b1, 4'hF, 1'b1, 1'b1, 8'd4, 4'h0, 1'b0, ST_START, 1'b1};
    tbl[4] = '{4'h3, 4'h8, 1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 8'd5, 4'h0, 1'b0, ST_START, 1'b1};
    tbl[5] = '{4'h3, 4'h8, 1'b1, 1'b0, 4'h3, 1'b0, 1'b1, 8'd6, 4'h0, 1'b0, ST_IDLE,  1'b0};
    tbl[6] = '{4'h5, 4'h4, 1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 8'd1, 4'h4, 1'b1, ST_HALT,  1'b0};

    for (int i = 0; i < BANKS; i++) dly[i] = 20;
    rst = 1'b1; run = 1'b0; clr = 1'b0; stop_on_err = 1'b0; bank_en = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_outs", 32'({bank_start, bank_we, bank_slow, bad_mask, pass_cnt}), 32'h0);
    chk("reset_flags", 32'({fail, busy, timeout, state_dbg}), 32'h0);

    // Four back-to-back passes, then disabled-bank bad and run drop
    for (int i = 0; i < 6; i++) apply_vec(tbl[i], $sformatf("v%0d", i));

    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_idle_cnt", 32'(pass_cnt), 32'h0);

    apply_vec(tbl[6], "v6");

    // HALT holds with run high: no start pulses, mode held
    ok = 1'b1;
    repeat (8) begin
      tick();
      if (bank_start != '0 || state_dbg != ST_HALT || busy) ok = 1'b0;
    end
    chk("halt_hold", 32'(ok), 32'h1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("halt_clr_flags", 32'({bad_mask, fail, pass_cnt}), 32'h0);
    chk("halt_clr_state", 32'(state_dbg), 32'(ST_HALT));
    run = 1'b0;
    tick();
    chk("halt_exit", 32'(state_dbg), 32'(ST_IDLE));

    // Run drop and bank_en change mid-WAIT; slow bank 3 sets the pass length
    dly[3] = 40;
    bank_en = 4'hF; bad_cfg = 4'h0; stop_on_err = 1'b0; run = 1'b1;
    #1;
    wait_start("midpass", 4'hF);
    prev = pass_cnt;
    el = 0;
    while (pass_cnt == prev && el < 200) begin
      tick();
      el++;
      if (el == 7) begin
        chk("midpass_wait", 32'(state_dbg), 32'(ST_WAIT));
        run = 1'b0;
        bank_en = 4'h1;
      end
    end
    chk("midpass_len", 32'(el), 32'd42);
    chk("midpass_cnt", 32'(pass_cnt), 32'd1);
    chk("midpass_idle", 32'({state_dbg, busy}), 32'({ST_IDLE, 1'b0}));
    dly[3] = 20;
    run = 1'b1;
    #1;
    wait_start("newen", 4'h1);
    run = 1'b0;
    el = 0;
    while (state_dbg != ST_IDLE && el < 200) begin
      tick();
      el++;
    end
    chk("newen_cnt", 32'(pass_cnt), 32'd2);

    // Stale done through START/ARM must not end the pass
    man_mode = 1'b1;
    man_done = 4'hF;
    bank_en = 4'hF;
    run = 1'b1;
    #1;
    wait_start("stale", 4'hF);
    tick();
    chk("stale_arm", 32'(state_dbg), 32'(ST_ARM));
    tick();
    man_done = 4'h0;
    chk("stale_noend", 32'(pass_cnt), 32'd2);
    repeat (3) tick();
    chk("stale_wait", 32'({state_dbg, pass_cnt}), 32'({ST_WAIT, 8'd2}));
    man_done = 4'hF;
    run = 1'b0;
    tick();
    chk("stale_end", 32'({state_dbg, pass_cnt}), 32'({ST_IDLE, 8'd3}));
    man_mode = 1'b0;

    // Reset in the middle of a pass (mode is r/w slow for pass_cnt=3)
    run = 1'b1;
    #1;
    wait_start("rstmid", 4'hF);
    repeat (5) tick();
    chk("rstmid_mode", 32'({bank_we, bank_slow}), 32'hFF);
    rst = 1'b1;
    run = 1'b0;
    tick();
    rst = 1'b0;
    chk("rstmid_outs", 32'({bank_start, bank_we, bank_slow, bad_mask, pass_cnt}), 32'h0);
    chk("rstmid_flags", 32'({fail, busy, timeout, state_dbg}), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/jtsdram_test_seq.md
Name: jtsdram_test_seq

Overview:
Top-level sequencer for the SDRAM bank verification testers: up to BANKS per-bank read/write checkers run in parallel.
- Latches the enabled bank set and issues one start pulse per pass.
- Selects the per-pass access mode (read/write, slow pacing).
- Waits for every enabled tester to finish, then accumulates per-bank error flags and counts completed passes.
- Sits between the OSD/debug control bits and the bank tester instances; drives their start/we/slow inputs and consumes their done/bad outputs.

Parameters:
BANKS, 4, number of bank testers sequenced
PASSW, 8, width of pass counter
TOW, 24, width of per-pass watchdog counter (used only with optional feature)

Ports:
rst  in  1  synchronous active-high reset
clk  in  1  single system clock; all logic on rising edge
run  in  1  level; high = keep looping passes
clr  in  1  pulse; clears pass_cnt, bad_mask, fail, timeout (IDLE/HALT only)
stop_on_err  in  1  halt after first failing pass
bank_en  in  BANKS  banks taking part; sampled in START only
bank_done  in  BANKS  tester done levels
bank_bad  in  BANKS  tester bad levels (sticky in tester)
bank_start  out  BANKS  one-cycle start pulse per enabled bank
bank_we  out  BANKS  tester write-enable mode, all bits equal
bank_slow  out  BANKS  tester slow-pacing mode, all bits equal
pass_cnt  out  PASSW  completed passes, wraps
bad_mask  out  BANKS  sticky per-bank failure
fail  out  1  OR of bad_mask
busy  out  1  high in any state except IDLE/HALT
timeout  out  1  sticky watchdog flag (0 without feature)

Behaviour:
- Reset: all outputs 0; state IDLE; en_l = 0. Reset takes effect at the next edge, including mid-pass; the testers are not touched.
- IDLE:
  - clr → clear counters/flags.
  - run && |bank_en → START.
- START (1 cycle):
  - en_l <= bank_en; bank_start = bank_en for this cycle only.
  - bank_we <= {BANKS{pass_cnt[1]}}; bank_slow <= {BANKS{pass_cnt[0]}}.
  - Resulting mode cycle: read fast, read slow, r/w fast, r/w slow, repeat.
  - → ARM.
- ARM (1 cycle): done is ignored here (testers clear done one cycle after start). → WAIT.
- WAIT: pass ends when (bank_done & en_l) == en_l. On that cycle:
  - bad_mask <= bad_mask | (bank_bad & en_l).
  - pass_cnt <= pass_cnt + 1, wrapping from all-ones to 0.
  - Next state:
    - new bit set in bad_mask && stop_on_err → HALT;
    - else run → START (back-to-back, no idle cycle);
    - else → IDLE.
- HALT:
  - busy = 0; the bank_we/bank_slow outputs hold their values.
  - Leaves only when run = 0: to IDLE (clr in the same cycle also clears).
  - clr while run = 1 clears the flags but stays in HALT.
- bank_en changes mid-pass: ignored until the next START.
- run dropping mid-pass: the pass completes and is counted, then IDLE.
- clr in START/ARM/WAIT: ignored.
- Disabled banks: bits get no start pulse and are never added to bad_mask.
- fail is registered and tracks |bad_mask with one cycle of latency at most. It is 0 after reset or clr.
- bank_we/bank_slow are registered and stable for the whole pass.

Optional Feature:
JTSDRAM_TIMEOUT_EN
- Defined:
  - A TOW-bit counter clears in START and increments each WAIT cycle.
  - When it reaches all-ones before the pass completes:
    - bad_mask |= en_l & ~bank_done;
    - timeout <= 1 (sticky until clr/rst);
    - pass_cnt increments;
    - next state chosen as at a normal pass end, with the timed-out banks counting as new failures.
- Undefined: no counter; timeout tied 0; WAIT waits indefinitely.

Test Plan:
1. rst, run=1, bank_en=4'b1111, testers assert done 20 cycles after start, bad=0 → bank_start=4'hF for exactly 1 cycle; pass_cnt 0→1→2→3→4 over four passes; bank_we/bank_slow sequence 0/0, 0/1, 1/0, 1/1; fail=0.
2. bank_en=4'b0101, bank 2 reports bad, stop_on_err=1 → after pass 1: bad_mask=4'b0100, fail=1, state HALT, busy=0, pass_cnt=1; no further start pulses until run=0.
3. bank_en=4'b0011, bank_bad[3]=1 (disabled bank) → bad_mask stays 0, bank_start=4'b0011 each pass.
4. run dropped 5 cycles into WAIT → pass finishes, pass_cnt increments by 1, IDLE, busy=0; bank_en change during WAIT has no effect on bank_start until next START.
5. Stale bank_done=1 held through START/ARM then low 1 cycle later → pass not ended in ARM; ends only on the later done rise.
6. With JTSDRAM_TIMEOUT_EN, TOW=6, bank 1 never done → after 63 WAIT cycles timeout=1, bad_mask[1]=1, pass_cnt=1; clr in HALT/IDLE returns all flags to 0.
